// File: rtl/tilelink_mto1_rr_arbiter.sv
// TileLink-UL M-to-1 merge: round-robin A arbitration with burst lock and per-master credits, D routed back by source tag.
// Zero-latency combinational A/D paths; a master stalls while not granted, out of credits, or when the slave/master deasserts ready.
module tilelink_mto1_rr_arbiter #(
    parameter int M       = 4,
    parameter int TL_DW   = 32,
    parameter int TL_AW   = 32,
    parameter int TL_RS   = 4,
    parameter int TL_SZ   = 4,
    parameter int MAX_OUT = 4,
    localparam int MW     = $clog2(M)
) (
    input  logic                   tilelink_clock_i,
    input  logic                   tilelink_reset_i,
    input  logic [3*M-1:0]         master_a_opcode,
    input  logic [3*M-1:0]         master_a_param,
    input  logic [M*TL_SZ-1:0]     master_a_size,
    input  logic [M*TL_RS-1:0]     master_a_source,
    input  logic [M*TL_AW-1:0]     master_a_address,
    input  logic [M*TL_DW/8-1:0]   master_a_mask,
    input  logic [M*TL_DW-1:0]     master_a_data,
    input  logic [M-1:0]           master_a_corrupt,
    input  logic [M-1:0]           master_a_valid,
    output logic [M-1:0]           master_a_ready,
    output logic [3*M-1:0]         master_d_opcode,
    output logic [2*M-1:0]         master_d_param,
    output logic [M*TL_SZ-1:0]     master_d_size,
    output logic [M*TL_RS-1:0]     master_d_source,
    output logic [M-1:0]           master_d_denied,
    output logic [M-1:0]           master_d_corrupt,
    output logic [M*TL_DW-1:0]     master_d_data,
    output logic [M-1:0]           master_d_valid,
    input  logic [M-1:0]           master_d_ready,
    output logic [2:0]             slave_a_opcode,
    output logic [2:0]             slave_a_param,
    output logic [TL_SZ-1:0]       slave_a_size,
    output logic [TL_RS+MW-1:0]    slave_a_source,
    output logic [TL_AW-1:0]       slave_a_address,
    output logic [TL_DW/8-1:0]     slave_a_mask,
    output logic [TL_DW-1:0]       slave_a_data,
    output logic                   slave_a_corrupt,
    output logic                   slave_a_valid,
    input  logic                   slave_a_ready,
    input  logic [2:0]             slave_d_opcode,
    input  logic [1:0]             slave_d_param,
    input  logic [TL_SZ-1:0]       slave_d_size,
    input  logic [TL_RS+MW-1:0]    slave_d_source,
    input  logic                   slave_d_denied,
    input  logic                   slave_d_corrupt,
    input  logic [TL_DW-1:0]       slave_d_data,
    input  logic                   slave_d_valid,
    output logic                   slave_d_ready,
    output logic                   error_o
);

    localparam int CW  = 1 << TL_SZ;
    localparam int LBW = $clog2(TL_DW/8);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    function automatic logic [CW-1:0] f_beats(input logic [2:0] op, input logic [TL_SZ-1:0] sz);
        logic [CW-1:0] b;
        b = CW'(1);
        if (op <= 3'd1 && int'(sz) > LBW) b = CW'(1) << (int'(sz) - LBW);
        return b;
    endfunction

    logic [0:0]    state_q, state_d;
    logic [MW-1:0] lock_q, lock_d;
    logic [MW-1:0] rr_q, rr_d;
    logic [CW-1:0] a_cnt_q, a_cnt_d;
    logic [CW-1:0] d_cnt_q, d_cnt_d;
    logic [3:0]    out_cnt_q [M];
    logic          err_q, err_d;

    logic [M-1:0]     elig;
    logic             gnt_vld;
    logic [MW-1:0]    gnt_idx;
    logic [TL_RS-1:0] src_m;
    logic [CW-1:0]    a_beats, d_beats;
    logic             a_fire, a_first, a_last;
    logic [MW-1:0]    d_idx;
    logic             d_routable, d_fire, d_last;

    always_comb begin
        for (int i = 0; i < M; i++)
            elig[i] = master_a_valid[i] && (out_cnt_q[i] < 4'(MAX_OUT));
    end

    // Scan downward so the eligible master closest at/after rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state_q == ST_BURST) begin
            gnt_idx = lock_q;
            for (int i = 0; i < M; i++)
                if (lock_q == MW'(i)) gnt_vld = master_a_valid[i];
        end else begin
            for (int k = M - 1; k >= 0; k--) begin
                if (elig[(int'(rr_q) + k) % M]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = MW'((int'(rr_q) + k) % M);
                end
            end
        end
    end

    always_comb begin
        slave_a_opcode  = '0;
        slave_a_param   = '0;
        slave_a_size    = '0;
        slave_a_address = '0;
        slave_a_mask    = '0;
        slave_a_data    = '0;
        slave_a_corrupt = 1'b0;
        src_m           = '0;
        for (int i = 0; i < M; i++) begin
            if (gnt_idx == MW'(i)) begin
                slave_a_opcode  = master_a_opcode[3*i +: 3];
                slave_a_param   = master_a_param[3*i +: 3];
                slave_a_size    = master_a_size[TL_SZ*i +: TL_SZ];
                slave_a_address = master_a_address[TL_AW*i +: TL_AW];
                slave_a_mask    = master_a_mask[(TL_DW/8)*i +: (TL_DW/8)];
                slave_a_data    = master_a_data[TL_DW*i +: TL_DW];
                slave_a_corrupt = master_a_corrupt[i];
                src_m           = master_a_source[TL_RS*i +: TL_RS];
            end
        end
        slave_a_source = {gnt_idx, src_m};
    end

    assign slave_a_valid = gnt_vld & ~tilelink_reset_i;

    always_comb begin
        for (int i = 0; i < M; i++)
            master_a_ready[i] = slave_a_ready & slave_a_valid & (gnt_idx == MW'(i));
    end

    assign a_beats = f_beats(slave_a_opcode, slave_a_size);
    assign a_fire  = slave_a_valid & slave_a_ready;
    assign a_first = a_fire & (state_q == ST_IDLE);
    assign a_last  = a_fire & ((state_q == ST_IDLE) ? (a_beats == CW'(1)) : (a_cnt_q == CW'(1)));

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        a_cnt_d = a_cnt_q;
        rr_d    = rr_q;
        if (state_q == ST_IDLE) begin
            if (a_fire && a_beats != CW'(1)) begin
                state_d = ST_BURST;
                lock_d  = gnt_idx;
                a_cnt_d = a_beats - CW'(1);
            end
        end else if (a_fire) begin
            a_cnt_d = a_cnt_q - CW'(1);
            if (a_cnt_q == CW'(1)) state_d = ST_IDLE;
        end
        if (a_last) rr_d = (gnt_idx == MW'(M - 1)) ? '0 : gnt_idx + MW'(1);
    end

    assign d_idx      = slave_d_source[TL_RS+MW-1:TL_RS];
    assign d_routable = (int'(d_idx) < M);

    assign master_d_opcode  = {M{slave_d_opcode}};
    assign master_d_param   = {M{slave_d_param}};
    assign master_d_size    = {M{slave_d_size}};
    assign master_d_source  = {M{slave_d_source[TL_RS-1:0]}};
    assign master_d_denied  = {M{slave_d_denied}};
    assign master_d_corrupt = {M{slave_d_corrupt}};
    assign master_d_data    = {M{slave_d_data}};

    // Unroutable beats are swallowed so a bad tag cannot wedge the slave.
    always_comb begin
        slave_d_ready  = ~d_routable;
        master_d_valid = '0;
        for (int i = 0; i < M; i++) begin
            if (d_idx == MW'(i)) begin
                master_d_valid[i] = slave_d_valid & d_routable & ~tilelink_reset_i;
                slave_d_ready     = master_d_ready[i];
            end
        end
    end

    assign d_beats = (slave_d_opcode == 3'd1) ? f_beats(3'd0, slave_d_size) : CW'(1);
    assign d_fire  = slave_d_valid & slave_d_ready & ~tilelink_reset_i;
    assign d_last  = d_fire & (d_cnt_q == d_beats - CW'(1));
    assign d_cnt_d = d_fire ? (d_last ? '0 : d_cnt_q + CW'(1)) : d_cnt_q;
    assign err_d   = err_q | (d_fire & ~d_routable);
    assign error_o = err_q;

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            rr_q    <= '0;
            a_cnt_q <= '0;
            d_cnt_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < M; i++) out_cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            a_cnt_q <= a_cnt_d;
            d_cnt_q <= d_cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < M; i++) begin
                if ((a_first && gnt_idx == MW'(i)) && !(d_last && d_routable && d_idx == MW'(i)))
                    out_cnt_q[i] <= out_cnt_q[i] + 4'd1;
                else if (!(a_first && gnt_idx == MW'(i)) && (d_last && d_routable && d_idx == MW'(i)))
                    out_cnt_q[i] <= out_cnt_q[i] - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tilelink_mto1_rr_arbiter.sv
// Bench for tilelink_mto1_rr_arbiter: a 4-master instance with two credits and a 3-master instance for bad-tag routing.
module tb_tilelink_mto1_rr_arbiter;
    localparam int M = 4, DW = 32, AW = 32, RS = 4, SZ = 4, MW = 2, SW = RS + MW;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3*M-1:0] a_op, a_par;
    logic [M*SZ-1:0] a_sz;
    logic [M*RS-1:0] a_src;
    logic [M*AW-1:0] a_adr;
    logic [M*DW/8-1:0] a_msk;
    logic [M*DW-1:0] a_dat;
    logic [M-1:0] a_cor, a_vld, a_rdy;
    logic [3*M-1:0] md_op;
    logic [2*M-1:0] md_par;
    logic [M*SZ-1:0] md_sz;
    logic [M*RS-1:0] md_src;
    logic [M-1:0] md_den, md_cor, md_vld, md_rdy;
    logic [M*DW-1:0] md_dat;
    logic [2:0] sa_op, sa_par;
    logic [SZ-1:0] sa_sz;
    logic [SW-1:0] sa_src;
    logic [AW-1:0] sa_adr;
    logic [DW/8-1:0] sa_msk;
    logic [DW-1:0] sa_dat;
    logic sa_cor, sa_vld, sa_rdy;
    logic [2:0] sd_op;
    logic [1:0] sd_par;
    logic [SZ-1:0] sd_sz;
    logic [SW-1:0] sd_src;
    logic sd_den, sd_cor, sd_vld, sd_rdy;
    logic [DW-1:0] sd_dat;
    logic err;

    logic [3*N3-1:0] t_a_op, t_a_par, t_md_op;
    logic [N3*SZ-1:0] t_a_sz, t_md_sz;
    logic [N3*RS-1:0] t_a_src, t_md_src;
    logic [N3*AW-1:0] t_a_adr;
    logic [N3*DW/8-1:0] t_a_msk;
    logic [N3*DW-1:0] t_a_dat, t_md_dat;
    logic [N3-1:0] t_a_cor, t_a_vld, t_a_rdy, t_md_den, t_md_cor, t_md_vld, t_md_rdy;
    logic [2*N3-1:0] t_md_par;
    logic [2:0] t_sa_op, t_sa_par;
    logic [SZ-1:0] t_sa_sz;
    logic [SW-1:0] t_sa_src, t_sd_src;
    logic [AW-1:0] t_sa_adr;
    logic [DW/8-1:0] t_sa_msk;
    logic [DW-1:0] t_sa_dat;
    logic t_sa_cor, t_sa_vld, t_sa_rdy, t_sd_vld, t_sd_rdy, t_err;

    tilelink_mto1_rr_arbiter #(.M(M), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ), .MAX_OUT(2)) u4 (
        .tilelink_clock_i(clk), .tilelink_reset_i(rst),
        .master_a_opcode(a_op), .master_a_param(a_par), .master_a_size(a_sz), .master_a_source(a_src),
        .master_a_address(a_adr), .master_a_mask(a_msk), .master_a_data(a_dat), .master_a_corrupt(a_cor),
        .master_a_valid(a_vld), .master_a_ready(a_rdy),
        .master_d_opcode(md_op), .master_d_param(md_par), .master_d_size(md_sz), .master_d_source(md_src),
        .master_d_denied(md_den), .master_d_corrupt(md_cor), .master_d_data(md_dat), .master_d_valid(md_vld),
        .master_d_ready(md_rdy),
        .slave_a_opcode(sa_op), .slave_a_param(sa_par), .slave_a_size(sa_sz), .slave_a_source(sa_src),
        .slave_a_address(sa_adr), .slave_a_mask(sa_msk), .slave_a_data(sa_dat), .slave_a_corrupt(sa_cor),
        .slave_a_valid(sa_vld), .slave_a_ready(sa_rdy),
        .slave_d_opcode(sd_op), .slave_d_param(sd_par), .slave_d_size(sd_sz), .slave_d_source(sd_src),
        .slave_d_denied(sd_den), .slave_d_corrupt(sd_cor), .slave_d_data(sd_dat), .slave_d_valid(sd_vld),
        .slave_d_ready(sd_rdy), .error_o(err));

    tilelink_mto1_rr_arbiter #(.M(N3), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ), .MAX_OUT(4)) u3 (
        .tilelink_clock_i(clk), .tilelink_reset_i(rst),
        .master_a_opcode(t_a_op), .master_a_param(t_a_par), .master_a_size(t_a_sz), .master_a_source(t_a_src),
        .master_a_address(t_a_adr), .master_a_mask(t_a_msk), .master_a_data(t_a_dat), .master_a_corrupt(t_a_cor),
        .master_a_valid(t_a_vld), .master_a_ready(t_a_rdy),
        .master_d_opcode(t_md_op), .master_d_param(t_md_par), .master_d_size(t_md_sz), .master_d_source(t_md_src),
        .master_d_denied(t_md_den), .master_d_corrupt(t_md_cor), .master_d_data(t_md_dat), .master_d_valid(t_md_vld),
        .master_d_ready(t_md_rdy),
        .slave_a_opcode(t_sa_op), .slave_a_param(t_sa_par), .slave_a_size(t_sa_sz), .slave_a_source(t_sa_src),
        .slave_a_address(t_sa_adr), .slave_a_mask(t_sa_msk), .slave_a_data(t_sa_dat), .slave_a_corrupt(t_sa_cor),
        .slave_a_valid(t_sa_vld), .slave_a_ready(t_sa_rdy),
        .slave_d_opcode(sd_op), .slave_d_param(sd_par), .slave_d_size(sd_sz), .slave_d_source(t_sd_src),
        .slave_d_denied(sd_den), .slave_d_corrupt(sd_cor), .slave_d_data(sd_dat), .slave_d_valid(t_sd_vld),
        .slave_d_ready(t_sd_rdy), .error_o(t_err));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_b;
        logic [3:0] vld;
        logic       srdy;
        logic [2:0] op2;
        logic [3:0] sz2;
        logic [3:0] e_rdy;
        logic       e_svld;
        logic [1:0] e_idx;
    } vec_t;
    vec_t tbl[$];
    logic [SW+AW-1:0] sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Masters default to single-beat Get; master 2 carries the opcode/size under test.
    task automatic set_a(input logic [3:0] vld, input logic [2:0] op2, input logic [3:0] sz2);
        for (int i = 0; i < M; i++) begin
            a_op[3*i +: 3]   = (i == 2) ? op2 : 3'd4;
            a_sz[SZ*i +: SZ] = (i == 2) ? sz2 : 4'd2;
            a_src[RS*i +: RS] = 4'(i + 5);
            a_adr[AW*i +: AW] = 32'(i * 256);
            a_dat[DW*i +: DW] = 32'(32'hA000 + i);
        end
        a_vld = vld;
    endtask

    task automatic set_d(input logic vld, input logic [2:0] op, input logic [3:0] sz, input logic [SW-1:0] src);
        sd_vld = vld;
        sd_op  = op;
        sd_sz  = sz;
        sd_src = src;
    endtask

    task automatic mon_a(input string nm);
        if (sa_vld && sa_rdy) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: unexpected A fire src %0h, nothing expected", nm, sa_src);
            end else begin
                chk(nm, {sa_src, sa_adr}, sb.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_vld = '0;
        sd_vld = 1'b0;
        t_sd_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        a_par = '0; a_msk = '1; a_cor = '0; md_rdy = '1; sa_rdy = 1'b1;
        sd_par = '0; sd_den = 1'b0; sd_cor = 1'b0; sd_dat = 32'hDEAD_BEEF;
        set_a(4'hF, 3'd4, 4'd2);
        set_d(1'b1, 3'd0, 4'd2, {2'd1, 4'd3});
        t_a_op = '0; t_a_par = '0; t_a_sz = '0; t_a_src = '0; t_a_adr = '0; t_a_msk = '0;
        t_a_dat = '0; t_a_cor = '0; t_a_vld = '0; t_md_rdy = '1; t_sa_rdy = 1'b1;
        t_sd_vld = 1'b0; t_sd_src = '0;

        @(negedge clk);
        #1;
        chk("reset slave_a_valid", sa_vld, 0);
        chk("reset master_a_ready", a_rdy, 0);
        chk("reset master_d_valid", md_vld, 0);
        chk("reset error_o", err, 0);

        tbl.push_back('{1'b1, 4'hF, 1'b0, 3'd4, 4'd2, 4'h0, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h1, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h2, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h8, 1'b1, 2'd3});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h1, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h2, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h8, 1'b1, 2'd3});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h0, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 4'hC, 1'b1, 3'd0, 4'd4, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd0, 4'd4, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b0, 3'd0, 4'd4, 4'h0, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd0, 4'd4, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd0, 4'd4, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 3'd4, 4'd2, 4'h8, 1'b1, 2'd3});

        sd_vld = 1'b0;
        foreach (tbl[r]) begin
            if (tbl[r].rst_b) do_reset();
            @(negedge clk);
            set_a(tbl[r].vld, tbl[r].op2, tbl[r].sz2);
            sa_rdy = tbl[r].srdy;
            if (tbl[r].e_svld && tbl[r].srdy)
                sb.push_back({tbl[r].e_idx, 4'(tbl[r].e_idx + 5), 32'(tbl[r].e_idx * 256)});
            #1;
            chk($sformatf("row%0d master_a_ready", r), a_rdy, tbl[r].e_rdy);
            chk($sformatf("row%0d slave_a_valid", r), sa_vld, tbl[r].e_svld);
            mon_a($sformatf("row%0d scoreboard", r));
        end
        chk("scoreboard drained", sb.size(), 0);
        sa_rdy = 1'b1;

        // Credit limit: third Get from master 0 stalls until its AccessAck lands.
        do_reset();
        @(negedge clk); set_a(4'b0001, 3'd4, 4'd2); #1; chk("cred get1 ready", a_rdy, 4'b0001);
        @(negedge clk); #1; chk("cred get2 ready", a_rdy, 4'b0001);
        @(negedge clk); set_a(4'b0011, 3'd4, 4'd2); #1; chk("cred m1 passes", a_rdy, 4'b0010);
        @(negedge clk); set_a(4'b0001, 3'd4, 4'd2); set_d(1'b1, 3'd0, 4'd2, {2'd0, 4'd7}); #1;
        chk("cred m0 stalled", a_rdy, 4'b0000);
        chk("ack d_valid", md_vld, 4'b0001);
        chk("ack d_source", md_src[3:0], 4'd7);
        chk("ack slave_d_ready", sd_rdy, 1'b1);
        @(negedge clk); sd_vld = 1'b0; #1; chk("cred m0 re-eligible", a_rdy, 4'b0001);

        // Two-beat AccessAckData to master 1 with downstream backpressure.
        do_reset();
        @(negedge clk); set_a(4'b0010, 3'd4, 4'd2); #1; chk("d4 get1", a_rdy, 4'b0010);
        @(negedge clk); #1; chk("d4 get2", a_rdy, 4'b0010);
        @(negedge clk); set_d(1'b1, 3'd1, 4'd3, {2'd1, 4'd5}); md_rdy = 4'b0010; #1;
        chk("beat1 d_valid", md_vld, 4'b0010);
        chk("beat1 d_source", md_src[7:4], 4'd5);
        chk("beat1 d_data", md_dat[DW +: DW], 32'hDEAD_BEEF);
        chk("beat1 m1 no credit", a_rdy, 4'b0000);
        @(negedge clk); md_rdy = 4'b0000; #1;
        chk("hold slave_d_ready", sd_rdy, 1'b0);
        chk("hold d_valid", md_vld, 4'b0010);
        chk("hold m1 no credit", a_rdy, 4'b0000);
        @(negedge clk); md_rdy = 4'b0010; #1;
        chk("beat2 slave_d_ready", sd_rdy, 1'b1);
        chk("beat2 m1 no credit yet", a_rdy, 4'b0000);
        @(negedge clk); sd_vld = 1'b0; md_rdy = '1; #1;
        chk("after burst m1 eligible", a_rdy, 4'b0010);

        // Three masters: tag 3 is unroutable.
        do_reset();
        @(negedge clk); t_sd_vld = 1'b1; t_sd_src = {2'd3, 4'd1}; t_md_rdy = 3'b000; sd_op = 3'd0; #1;
        chk("bad tag slave_d_ready", t_sd_rdy, 1'b1);
        chk("bad tag d_valid", t_md_vld, 3'b000);
        chk("bad tag error same cycle", t_err, 1'b0);
        @(negedge clk); t_sd_vld = 1'b0; #1; chk("error set", t_err, 1'b1);
        @(negedge clk); t_sd_vld = 1'b1; t_sd_src = {2'd2, 4'd1}; t_md_rdy = 3'b100; #1;
        chk("m3 route idx2", t_md_vld, 3'b100);
        chk("error sticky", t_err, 1'b1);
        do_reset();
        #1; chk("error cleared by reset", t_err, 1'b0);

        // Reset in the middle of a four-beat burst from master 2.
        @(negedge clk); set_a(4'b0100, 3'd0, 4'd4); #1; chk("burst beat1", a_rdy, 4'b0100);
        @(negedge clk); rst = 1'b1; set_a(4'b1111, 3'd0, 4'd4); #1; chk("reset blocks slave_a_valid", sa_vld, 1'b0);
        @(negedge clk); rst = 1'b0; set_a(4'b0110, 3'd4, 4'd2); #1;
        chk("post-reset grant m1", a_rdy, 4'b0010);
        chk("post-reset source idx", sa_src[5:4], 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tilelink_mto1_rr_arbiter.md
Name: tilelink_mto1_rr_arbiter

Overview:
- TileLink-UL M-to-1 arbiter: the next-generation per-slave merge stage for the crossbar.
- Adds fair round-robin A-channel arbitration with multi-beat burst locking.
- Adds per-master outstanding-transaction credit limiting and a sticky error flag for unroutable D responses.
- Tags A source with the master index; routes D responses back by that tag.

Parameters:
M, 4, number of masters (must be >= 2); MW = $clog2(M)
TL_DW, 32, data width in bits (power of 2, >= 8)
TL_AW, 32, address width
TL_RS, 4, master-side source width
TL_SZ, 4, size field width (log2 bytes)
MAX_OUT, 4, max outstanding messages per master (1..15)

Ports:
tilelink_clock_i  in  1  clock
tilelink_reset_i  in  1  synchronous active-high reset
master_a_opcode/param  in  3*M each  per-master A opcode/param, master i at bits [3i+2:3i]
master_a_size  in  M*TL_SZ  A size
master_a_source  in  M*TL_RS  A source
master_a_address  in  M*TL_AW  A address
master_a_mask  in  M*TL_DW/8  A byte mask
master_a_data  in  M*TL_DW  A data
master_a_corrupt, master_a_valid  in  M  A corrupt / valid
master_a_ready  out  M  A ready
master_d_opcode  out  3*M; master_d_param  out  2*M; master_d_size  out  M*TL_SZ; master_d_source  out  M*TL_RS
master_d_denied, master_d_corrupt, master_d_valid  out  M; master_d_data  out  M*TL_DW
master_d_ready  in  M  D ready
slave_a_*  out  single-channel A fields; slave_a_source width TL_RS+MW; slave_a_ready in 1
slave_d_*  in  single-channel D fields; slave_d_source width TL_RS+MW; slave_d_ready out 1
error_o  out  1  sticky: D response arrived with master index >= M

Behaviour:
- Reset: state IDLE, rr pointer 0, all beat counters and outstanding counters 0, error_o 0.
- Reset mid-burst aborts the burst and returns to IDLE; slave_a_valid and all master_d_valid are 0 while reset is asserted.
- Beat count: beats = (opcode in {PutFull=0, PutPartial=1} and 2^size > TL_DW/8) ? 2^size/(TL_DW/8) : 1.
- D beat count uses the same formula for AccessAckData (opcode 1); AccessAck (opcode 0) is always 1 beat.
- Eligibility: master i is eligible iff master_a_valid[i] and out_cnt[i] < MAX_OUT.
- A-channel, IDLE state: the grant goes to the first eligible master at or after the rr pointer, modulo M.
- A grant path is combinational, zero-latency passthrough: slave_a_* = granted master fields; slave_a_source = {MW'(i), master source}; master_a_ready[i] = slave_a_ready & granted(i); all other readies 0.
- IDLE first beat with beats>1: on fire, latch the lock index, load a_cnt = beats-1, go to BURST.
- A-channel, BURST state: only the locked master is forwarded, regardless of out_cnt. Each fire decrements a_cnt. The fire with a_cnt==1 returns to IDLE.
- rr pointer: set to (granted index + 1) mod M on the fire of the last beat of each message (single-beat messages included). The pointer is unchanged when no fire occurs.
- Outstanding: out_cnt[i] increments on the first-beat fire of a message from master i. It decrements on the last-beat fire of a D message routed to i. Both events in the same cycle leave it unchanged.
- D-channel routing: idx = slave_d_source[TL_RS+MW-1:TL_RS]. master_d_valid[idx] = slave_d_valid; all fields are broadcast and source is truncated to TL_RS bits; slave_d_ready = master_d_ready[idx].
- D beat tracking: d_cnt counts beats of multi-beat responses; the message is complete when d_cnt reaches beats-1 on fire.
- Unroutable D (idx >= M, only possible when M is not a power of 2): slave_d_ready = 1, the beat is dropped, no master_d_valid is raised, and error_o is set until reset.
- Channel independence: A and D proceed concurrently with no ordering interlock.

Test Plan:
- M=4, all valid, single-beat Get, slave_a_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; slave_a_source upper bits 0,1,2,3,0.
- Master 2 sends PutFull size=4 (16B, TL_DW=32) while master 3 is valid -> 4 consecutive beats from master 2; master 3 is granted on the 5th cycle; rr pointer ends at 3.
- MAX_OUT=2, master 0 issues 2 Gets with D held off -> third Get stalls (master_a_ready[0]=0) and other masters proceed. Then AccessAck source={0,x} -> master 0 is re-eligible the next cycle.
- AccessAckData size=3 (2 beats) source={1,5}, master_d_ready[1] toggling 1,0,1 -> master 1 sees 2 beats with source 5; out_cnt[1] decrements only on the second beat.
- M=3, D source index 3 -> slave_d_ready=1, no master_d_valid, error_o=1 from the next cycle until reset.
- Reset asserted during beat 2 of a 4-beat burst -> next cycle state IDLE, counters 0; a new request from master 1 is granted with pointer 0 ordering.
